sdram_memtest: RTL

SDRAM_MEMTEST -- requirements
Module: sdram_memtest

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_memtest_lfsr16.sv | 21 ++
 rtl/sdram_memtest.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM memory tester and controller: default widths,
// tester state encoding and the 16-bit LFSR used as the test pattern source.
package sdram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    // Feedback taps at bits 0, 2, 3 and 5 of a right-shifting register realise
    // x^16 + x^14 + x^13 + x^11 + 1 in Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_WAIT_RD = 3'd3,
        S_PASS    = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/sdram_memtest_lfsr16.sv
// 16-bit Fibonacci LFSR pattern generator; reset and load both restore the seed.
module lfsr16
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sdram_memtest.sv
// SDRAM self-test: writes an LFSR pattern over TEST_WORDS words from address 0,
// reads it back one word at a time and reports pass/fail on the LEDs.
// Request handshake: a request transfers on a cycle with cmd_valid=1 and cmd_ready=1;
// while cmd_valid=1 and cmd_ready=0 the request fields are held and cmd_valid stays high.
module sdram_memtest
    import sdram_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          TEST_WORDS = 1024,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [2:0]        led,
    output logic [7:0]        debugline,
    output logic              done
);

    // Terminal-count compare so that testing the full address space needs no extra bit.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEST_WORDS - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [4:0]        err_cnt, err_cnt_d;
    logic [ADDR_W-1:0] first_err_addr, first_err_addr_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              lfsr_load, lfsr_step;
    logic              hs, last, mismatch;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign hs       = cmd_valid && cmd_ready;
    assign last     = (addr == LAST_ADDR);
    assign mismatch = (rd_data != DATA_W'(lfsr_q));
    assign cmd_addr = addr;

    always_comb begin
        state_d          = state;
        addr_d           = addr;
        err_cnt_d        = err_cnt;
        first_err_addr_d = first_err_addr;
        lfsr_load        = 1'b0;
        lfsr_step        = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done) begin
                    state_d   = S_WRITE;
                    addr_d    = '0;
                    lfsr_load = 1'b1;
                end
            end
            S_WRITE: begin
                if (hs) begin
                    if (last) begin
                        state_d   = S_READ;
                        addr_d    = '0;
                        lfsr_load = 1'b1;
                    end else begin
                        addr_d    = addr + 1'b1;
                        lfsr_step = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (hs) begin
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (rd_valid) begin
                    if (mismatch) begin
                        err_cnt_d = (err_cnt == 5'd31) ? err_cnt : err_cnt + 5'd1;
                        if (err_cnt == 5'd0) begin
                            first_err_addr_d = addr;
                        end
                    end
                    addr_d    = addr + 1'b1;
                    lfsr_step = 1'b1;
                    if (last) begin
                        state_d = (err_cnt_d == 5'd0) ? S_PASS : S_FAIL;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            default: ;
        endcase
        lfsr_d = lfsr_load ? SEED : (lfsr_step ? lfsr_next(lfsr_q) : lfsr_q);
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            addr           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            cmd_valid      <= 1'b0;
            cmd_we         <= 1'b0;
            cmd_wdata      <= '0;
            led            <= '0;
            debugline      <= '0;
            done           <= 1'b0;
        end else begin
            state          <= state_d;
            addr           <= addr_d;
            err_cnt        <= err_cnt_d;
            first_err_addr <= first_err_addr_d;
            cmd_valid      <= (state_d == S_WRITE) || (state_d == S_READ);
            cmd_we         <= (state_d == S_WRITE);
            cmd_wdata      <= (state_d == S_WRITE) ? DATA_W'(lfsr_d) : '0;
            led            <= {state_d == S_FAIL, state_d == S_PASS,
                               (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_WAIT_RD)};
            debugline      <= {state_d, err_cnt_d};
            done           <= (state_d == S_PASS) || (state_d == S_FAIL);
        end
    end

endmodule
